// File: rtl/dual_slope_adc_ctrl_if.sv
// Control/status bundle between the dual-slope sequencer and its requester / analog front end.
// master drives start and cmp; slave is the sequencer side.
interface dual_slope_adc_ctrl_if #(
  parameter int unsigned NB = 10
) ();
  logic          start;
  logic          cmp;
  logic          int_rst;
  logic          sel_ref;
  logic          busy;
  logic          done;
  logic          ovf;
  logic [NB-1:0] result;

  modport master (
    output start, cmp,
    input  int_rst, sel_ref, busy, done, ovf, result
  );

  modport slave (
    input  start, cmp,
    output int_rst, sel_ref, busy, done, ovf, result
  );
endinterface

// File: rtl/dual_slope_adc_ctrl.sv
// Dual-slope ADC sequencer: discharge, fixed-length run-up on the unknown input,
// then de-integrate against the reference and count until the comparator flips.
module dual_slope_adc_ctrl #(
  parameter int unsigned T_RST     = 4,
  parameter int unsigned N_INT     = 256,
  parameter int unsigned NB        = 10,
  parameter int unsigned MAX_DEINT = (1 << NB) - 1,
  parameter int unsigned N_SYNC    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  dual_slope_adc_ctrl_if.slave bus
);

  localparam int unsigned PH_MAX = (T_RST > N_INT) ? T_RST : N_INT;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RST   = 2'd1,
    S_INTEG = 2'd2,
    S_DEINT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic [NB-1:0]   cnt_q, cnt_d;
  logic [NB-1:0]   result_q, result_d;
  logic            int_rst_q, int_rst_d;
  logic            sel_ref_q, sel_ref_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic            cmp_s;

  // Comparator synchronizer; depth 0 uses the raw comparator.
  generate
    if (N_SYNC == 0) begin : g_nosync
      assign cmp_s = bus.cmp;
    end else begin : g_sync
      logic [N_SYNC-1:0] sync_q, sync_d;

      always_comb begin
        sync_d = (sync_q << 1) | N_SYNC'(bus.cmp);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign cmp_s = sync_q[N_SYNC-1];
    end
  endgenerate

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ph_q      <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      int_rst_q <= 1'b1;
      sel_ref_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      int_rst_q <= int_rst_d;
      sel_ref_q <= sel_ref_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    int_rst_d = int_rst_q;
    sel_ref_d = sel_ref_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        int_rst_d = 1'b1;
        sel_ref_d = 1'b0;
        busy_d    = 1'b0;
        if (bus.start) begin
          state_d = S_RST;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          ph_d    = '0;
        end
      end

      S_RST: begin
        int_rst_d = 1'b1;
        sel_ref_d = 1'b0;
        if (ph_q == PH_W'(T_RST - 1)) begin
          state_d   = S_INTEG;
          int_rst_d = 1'b0;
          ph_d      = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_INTEG: begin
        int_rst_d = 1'b0;
        sel_ref_d = 1'b0;
        if (ph_q == PH_W'(N_INT - 1)) begin
          state_d   = S_DEINT;
          sel_ref_d = 1'b1;
          cnt_d     = '0;
          ph_d      = '0;
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end

      S_DEINT: begin
        int_rst_d = 1'b0;
        sel_ref_d = 1'b1;
        if (!cmp_s) begin
          state_d   = S_IDLE;
          result_d  = cnt_q;
          done_d    = 1'b1;
          int_rst_d = 1'b1;
          sel_ref_d = 1'b0;
          busy_d    = 1'b0;
        end else if (cnt_q == NB'(MAX_DEINT)) begin
          // Comparator never flipped within the count range: saturate and flag.
          state_d   = S_IDLE;
          result_d  = NB'(MAX_DEINT);
          ovf_d     = 1'b1;
          done_d    = 1'b1;
          int_rst_d = 1'b1;
          sel_ref_d = 1'b0;
          busy_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + NB'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.int_rst = int_rst_q;
  assign bus.sel_ref = sel_ref_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_dual_slope_adc_ctrl.sv
// Bench for dual_slope_adc_ctrl: nominal, synchronized, overflow and closed-loop instances,
// with a done-driven scoreboard plus hand-timed corner sequences.
module tb_dual_slope_adc_ctrl;

  localparam int TA = 2;   // T_RST of the short instances
  localparam int NA = 8;   // N_INT of the short instances

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;

  dual_slope_adc_ctrl_if #(.NB(10)) if_a ();
  dual_slope_adc_ctrl_if #(.NB(10)) if_b ();
  dual_slope_adc_ctrl_if #(.NB(4))  if_c ();
  dual_slope_adc_ctrl_if #(.NB(10)) if_d ();

  dual_slope_adc_ctrl #(.T_RST(TA), .N_INT(NA), .NB(10), .MAX_DEINT(1023), .N_SYNC(0))
    u_a (.clk(clk), .reset(rst_a), .bus(if_a));
  dual_slope_adc_ctrl #(.T_RST(TA), .N_INT(NA), .NB(10), .MAX_DEINT(1023), .N_SYNC(2))
    u_b (.clk(clk), .reset(rst_b), .bus(if_b));
  dual_slope_adc_ctrl #(.T_RST(TA), .N_INT(NA), .NB(4), .MAX_DEINT(15), .N_SYNC(0))
    u_c (.clk(clk), .reset(rst_c), .bus(if_c));
  dual_slope_adc_ctrl #(.T_RST(4), .N_INT(256), .NB(10), .MAX_DEINT(1023), .N_SYNC(2))
    u_d (.clk(clk), .reset(rst_d), .bus(if_d));

  // Integrator model for the closed loop, in units of 0.5 V: +1 per cycle on the
  // 0.5 V input, -2 per cycle on the -1 V reference.
  int v_d = 0;
  always @(negedge clk) begin
    if (if_d.int_rst) v_d <= 0;
    else              v_d <= v_d + (if_d.sel_ref ? -2 : 1);
  end
  assign if_d.cmp = (v_d > 0);

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int res;
    int ovf;
    int edge_n;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];

  function automatic exp_t mk(input int res, input int ovf, input int edge_n);
    exp_t e;
    e.res = res; e.ovf = ovf; e.edge_n = edge_n;
    return e;
  endfunction

  // Scoreboard monitors: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (if_a.done) begin
      if (qa.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_result", int'(if_a.result), e.res);
        chk("a_ovf", int'(if_a.ovf), e.ovf);
        chk("a_done_edge", cyc, e.edge_n);
      end
    end
  end

  always @(negedge clk) begin
    if (if_b.done) begin
      if (qb.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_result", int'(if_b.result), e.res);
        chk("b_ovf", int'(if_b.ovf), e.ovf);
        chk("b_done_edge", cyc, e.edge_n);
      end
    end
  end

  always @(negedge clk) begin
    if (if_c.done) begin
      if (qc.size() == 0) chk("c_unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = qc.pop_front();
        chk("c_result", int'(if_c.result), e.res);
        chk("c_ovf", int'(if_c.ovf), e.ovf);
        chk("c_done_edge", cyc, e.edge_n);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Wait for all outstanding expectations; leftovers count as a failure.
  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk({name, "_pending"}, qa.size() + qb.size() + qc.size(), 0);
    qa.delete(); qb.delete(); qc.delete();
  endtask

  // One conversion on A and B together: cmp high for k DEINT edges, then low.
  task automatic run_ab(input int k, input bit integ_start, input int ra, input int rb);
    int e0;
    if_a.cmp = 1'b1; if_b.cmp = 1'b1;
    if_a.start = 1'b1; if_b.start = 1'b1;
    e0 = cyc + 1;
    qa.push_back(mk(ra, 0, e0 + TA + NA + k + 1));
    qb.push_back(mk(rb, 0, e0 + TA + NA + k + 3));
    @(negedge clk);
    if_a.start = 1'b0; if_b.start = 1'b0;
    if (integ_start) begin
      wait_cyc(e0 + TA + 3);
      if_a.start = 1'b1; if_b.start = 1'b1;
      @(negedge clk);
      if_a.start = 1'b0; if_b.start = 1'b0;
    end
    wait_cyc(e0 + TA + NA + k);
    if_a.cmp = 1'b0; if_b.cmp = 1'b0;
    drain("run_ab", 40);
  endtask

  typedef struct {
    int k;
    bit integ_start;
    int res_a;
    int res_b;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, e1, n;

    tbl[0] = '{5,  1'b0, 5,  7};
    tbl[1] = '{0,  1'b0, 0,  2};
    tbl[2] = '{12, 1'b1, 12, 14};
    tbl[3] = '{1,  1'b0, 1,  3};
    tbl[4] = '{20, 1'b1, 20, 22};
    tbl[5] = '{3,  1'b0, 3,  5};

    if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; if_d.start = 1'b0;
    if_a.cmp = 1'b0; if_b.cmp = 1'b0; if_c.cmp = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_int_rst", int'(if_a.int_rst), 1);
    chk("rst_sel_ref", int'(if_a.sel_ref), 0);
    chk("rst_busy",    int'(if_a.busy), 0);
    chk("rst_done",    int'(if_a.done), 0);
    chk("rst_ovf",     int'(if_a.ovf), 0);
    chk("rst_result",  int'(if_a.result), 0);
    chk("rst_c_int_rst", int'(if_c.int_rst), 1);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven conversions on the unsynchronized and synchronized instances.
    for (int i = 0; i < 6; i++) begin
      run_ab(tbl[i].k, tbl[i].integ_start, tbl[i].res_a, tbl[i].res_b);
    end

    // Nominal edge timing on A: k = 5.
    if_a.cmp = 1'b1; if_a.start = 1'b1;
    e0 = cyc + 1;
    qa.push_back(mk(5, 0, e0 + 16));
    @(negedge clk);
    if_a.start = 1'b0;
    chk("nom_busy_e0", int'(if_a.busy), 1);
    chk("nom_int_rst_e0", int'(if_a.int_rst), 1);
    wait_cyc(e0 + 1);  chk("nom_int_rst_e1", int'(if_a.int_rst), 1);
    wait_cyc(e0 + 2);  chk("nom_int_rst_e2", int'(if_a.int_rst), 0);
    wait_cyc(e0 + 9);  chk("nom_sel_ref_e9", int'(if_a.sel_ref), 0);
    wait_cyc(e0 + 10); chk("nom_sel_ref_e10", int'(if_a.sel_ref), 1);
    wait_cyc(e0 + 15); chk("nom_busy_e15", int'(if_a.busy), 1);
    if_a.cmp = 1'b0;
    wait_cyc(e0 + 16);
    chk("nom_busy_e16", int'(if_a.busy), 0);
    chk("nom_int_rst_e16", int'(if_a.int_rst), 1);
    chk("nom_sel_ref_e16", int'(if_a.sel_ref), 0);
    wait_cyc(e0 + 17); chk("nom_done_one_cycle", int'(if_a.done), 0);
    drain("nominal", 10);

    // Back-to-back: start asserted while done is high.
    if_a.cmp = 1'b1; if_a.start = 1'b1;
    e0 = cyc + 1;
    qa.push_back(mk(3, 0, e0 + 14));
    @(negedge clk);
    if_a.start = 1'b0;
    wait_cyc(e0 + 13); if_a.cmp = 1'b0;
    wait_cyc(e0 + 14);
    chk("b2b_done_seen", int'(if_a.done), 1);
    if_a.cmp = 1'b1; if_a.start = 1'b1;
    e1 = cyc + 1;
    qa.push_back(mk(6, 0, e1 + 17));
    @(negedge clk);
    if_a.start = 1'b0;
    chk("b2b_busy_restart", int'(if_a.busy), 1);
    chk("b2b_int_rst_restart", int'(if_a.int_rst), 1);
    chk("b2b_result_held0", int'(if_a.result), 3);
    wait_cyc(e1 + 12); chk("b2b_result_held1", int'(if_a.result), 3);
    wait_cyc(e1 + 16); if_a.cmp = 1'b0;
    drain("b2b", 20);

    // Reset in the middle of DEINT: no done, outputs back to reset values.
    if_a.cmp = 1'b1; if_a.start = 1'b1;
    e0 = cyc + 1;
    @(negedge clk);
    if_a.start = 1'b0;
    wait_cyc(e0 + 13);
    rst_a = 1'b1;
    wait_cyc(e0 + 14);
    chk("mid_rst_int_rst", int'(if_a.int_rst), 1);
    chk("mid_rst_sel_ref", int'(if_a.sel_ref), 0);
    chk("mid_rst_busy",    int'(if_a.busy), 0);
    chk("mid_rst_result",  int'(if_a.result), 0);
    chk("mid_rst_done",    int'(if_a.done), 0);
    rst_a = 1'b0;
    repeat (3) @(negedge clk);
    if_a.cmp = 1'b1; if_a.start = 1'b1;
    e0 = cyc + 1;
    qa.push_back(mk(2, 0, e0 + 13));
    @(negedge clk);
    if_a.start = 1'b0;
    wait_cyc(e0 + 12); if_a.cmp = 1'b0;
    drain("after_rst", 20);

    // Overflow on the 4-bit instance with cmp stuck high.
    if_c.cmp = 1'b1; if_c.start = 1'b1;
    e0 = cyc + 1;
    qc.push_back(mk(15, 1, e0 + TA + NA + 16));
    @(negedge clk);
    if_c.start = 1'b0;
    wait_cyc(e0 + 30);
    chk("ovf_held", int'(if_c.ovf), 1);
    chk("ovf_result_held", int'(if_c.result), 15);
    chk("ovf_idle_busy", int'(if_c.busy), 0);
    if_c.cmp = 1'b0; if_c.start = 1'b1;
    e1 = cyc + 1;
    qc.push_back(mk(0, 0, e1 + TA + NA + 1));
    @(negedge clk);
    if_c.start = 1'b0;
    chk("ovf_cleared_at_start", int'(if_c.ovf), 0);
    chk("ovf_result_kept", int'(if_c.result), 15);
    drain("ovf", 20);

    // Closed loop with the integrator model: 0.5 V in, -1 V ref, 256-cycle run-up.
    if_d.start = 1'b1;
    @(negedge clk);
    if_d.start = 1'b0;
    n = 0;
    while (!if_d.done && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("loop_done_seen", int'(if_d.done), 1);
    tests++;
    if (int'(if_d.result) < 125 || int'(if_d.result) > 131) begin
      fails++;
      $display("FAIL loop_result: got %0d, expected 128 +/- 3", int'(if_d.result));
    end
    chk("loop_ovf", int'(if_d.ovf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dual_slope_adc_ctrl.md
# dual_slope_adc_ctrl

Clocked sequencer that turns a PWL integrator with reset into a dual-slope ADC. It controls the integrator's reset and the input-select mux: discharge, integrate the unknown input for a fixed number of cycles, then de-integrate against a reference. It counts cycles until the integrator-sign comparator flips and reports the count as the conversion result. It sits between the digital control domain and the analog front end: integrator, input/reference mux and comparator.

## Interface
- T_RST, 4: cycles the integrator reset is held before each integration; must be ≥1.
- N_INT, 256: fixed run-up (signal integration) length in cycles; must be ≥1.
- NB, 10: result width in bits.
- MAX_DEINT, 2**NB-1: de-integration count limit (overflow threshold); must be ≤2**NB-1.
- N_SYNC, 2: comparator synchronizer depth; allowed values 0, 1, 2. A value of 0 feeds `cmp` directly.
- clk  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  conversion request, sampled only in IDLE.
- cmp  in  1  comparator output; 1 while the integrator output is > 0.
- int_rst  out  1  drives the integrator `reset`; 1 = hold output at the reset value.
- sel_ref  out  1  mux select; 0 = unknown input, 1 = negative reference.
- busy  out  1  high from the edge after start is accepted until done.
- done  out  1  one-cycle pulse when `result` is updated.
- ovf  out  1  set with done when the de-integration limit is reached; held until the next accepted start.
- result  out  NB  de-integration count; held between conversions.

## Operation
- All outputs are registered.
- Reset values: state=IDLE, int_rst=1, sel_ref=0, busy=0, done=0, ovf=0, result=0, counters=0, synchronizer flops=0.
- `cmp_s` is `cmp` delayed by N_SYNC flops. All comparator decisions use `cmp_s`.
- States and outputs:
  - IDLE: int_rst=1, sel_ref=0, busy=0. If start=1, go to RST, set busy=1, clear ovf and the phase counter.
  - RST: int_rst=1, sel_ref=0. Stays T_RST cycles, then goes to INTEG with int_rst=0.
  - INTEG: int_rst=0, sel_ref=0. Stays N_INT cycles, then goes to DEINT with sel_ref=1 and the count cleared to 0.
  - DEINT: int_rst=0, sel_ref=1. On each edge:
    - If cmp_s=1 and cnt<MAX_DEINT: cnt++.
    - If cmp_s=0: result←cnt, done←1, go to IDLE.
    - If cmp_s=1 and cnt==MAX_DEINT: result←MAX_DEINT, ovf←1, done←1, go to IDLE.
- On entering IDLE from DEINT, int_rst←1, sel_ref←0 and busy←0 on the same edge as done.
- Arithmetic:
  - The phase counter is wide enough for max(T_RST, N_INT).
  - cnt is NB bits and never wraps; it saturates at MAX_DEINT.
- Boundary cases:
  - start while busy: ignored, with no queueing.
  - start on the done cycle: accepted, because the state is IDLE.
  - cmp_s=0 on the first DEINT edge: result=0, done; this is the negative or zero input case.
  - reset mid-conversion: next edge returns to IDLE with reset values. result is cleared and no done is issued.
  - cmp changes during RST/INTEG: ignored; only the synchronizer shifts.

## Timing
- Edge 0 is the edge where start=1 is sampled in IDLE.
- RST occupies edges 0..T_RST. int_rst falls at edge T_RST.
- sel_ref rises at edge T_RST+N_INT.
- If cmp_s is 1 for k DEINT edges and then 0: done and the result update occur at edge T_RST+N_INT+k+1, with result=k.
- Comparator latency is N_SYNC cycles. The result includes N_SYNC extra counts relative to the true crossing and is not compensated.
- Conversion time is T_RST+N_INT+k+1 cycles. The next start can be accepted on the done cycle.

## Test plan
- Nominal (T_RST=2, N_INT=8, N_SYNC=0): start at edge 0; cmp=1 for 5 DEINT cycles, then 0.
  - Required: int_rst falls at edge 2, sel_ref rises at edge 10, done at edge 16, result=5, ovf=0, busy low at edge 16.
- Zero or negative input: cmp=0 throughout DEINT.
  - Required: done at edge T_RST+N_INT+1, result=0, ovf=0.
- Overflow (NB=4, MAX_DEINT=15): cmp stuck at 1.
  - Required: done after 16 DEINT edges, result=15, ovf=1. ovf stays 1 until the next start and clears at that start edge.
- Synchronizer (N_SYNC=2): same stimulus as the nominal case.
  - Required: result=7, done at edge 18.
- Back-to-back and ignored start:
  - start pulses during INTEG: no effect on sequencing.
  - start asserted on the done cycle: a new RST begins at that edge, and result holds the previous value until the next done.
- Reset mid-DEINT:
  - On the next edge: int_rst=1, sel_ref=0, busy=0, result=0, no done pulse.
  - A subsequent start converts normally.
- Closed loop with the PWL integrator model (gain=1, input 0.5 V, reference −1 V, N_INT=256):
  - Required: result=128±(N_SYNC+1).
